// File: rtl/rename_pkg.sv
// Shared types for the rename slice: map-table entry layout, recovery FSM
// encoding and the hardwired-zero physical tag.
package rename_pkg;

   localparam int DEF_NUM_AREGS = 32;
   localparam int DEF_NUM_PREGS = 64;
   localparam int AREG_BITS     = $clog2(DEF_NUM_AREGS);
   localparam int PREG_BITS     = $clog2(DEF_NUM_PREGS);

   typedef logic [AREG_BITS-1:0] areg_t;
   typedef logic [PREG_BITS-1:0] preg_t;

   // One map-table entry; packs as {tag, ready} with ready in bit 0.
   typedef struct packed {
      preg_t tag;
      logic  ready;
   } tag_and_ready_t;

   typedef enum logic [1:0] {
      NORMAL      = 2'd0,
      WAIT_RETIRE = 2'd1,
      RESTORE     = 2'd2
   } execution_state_e;

   // x0 always renames to preg 0.
   localparam preg_t ZERO_PREG = '0;

endpackage

// File: rtl/rename_unit_map_table_bank.sv
// One full areg->{tag,ready} table. Priority write ports (highest port wins),
// CDB ready-bit broadcast, and a whole-table copy-in that overrides both.
// SHOW_NEXT selects whether table_o shows the stored table or its next value.
module map_table_bank #(
   parameter int NUM_AREGS = 32,
   parameter int AREG_W    = 5,
   parameter int PREG_W    = 6,
   parameter int NUM_WR    = 2,
   parameter int NUM_CDB   = 2,
   parameter bit SHOW_NEXT = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_WR-1:0] wr_en,
   input  logic [AREG_W-1:0] wr_addr   [NUM_WR],
   input  logic [PREG_W:0]   wr_data   [NUM_WR],
   input  logic [NUM_CDB-1:0] cdb_valid,
   input  logic [PREG_W-1:0] cdb_tag   [NUM_CDB],
   input  logic              copy_en,
   input  logic [PREG_W:0]   copy_data [NUM_AREGS],
   output logic [PREG_W:0]   table_o   [NUM_AREGS]
);

   logic [PREG_W:0] table_q [NUM_AREGS];
   logic [PREG_W:0] table_d [NUM_AREGS];

   // Next table: CDB wake-ups, then write ports in ascending priority, then copy-in.
   always_comb begin
      for (int a = 0; a < NUM_AREGS; a++) begin
         table_d[a] = table_q[a];
         for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid[c] && (table_q[a][PREG_W:1] == cdb_tag[c])) begin
               table_d[a][0] = 1'b1;
            end
         end
      end
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en[w]) begin
            table_d[wr_addr[w]] = wr_data[w];
         end
      end
      if (copy_en) begin
         for (int a = 0; a < NUM_AREGS; a++) begin
            table_d[a] = copy_data[a];
         end
      end
   end

   // Table storage; reset restores the identity mapping, all ready.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int a = 0; a < NUM_AREGS; a++) begin
            table_q[a] <= {PREG_W'(a), 1'b1};
         end
      end else begin
         table_q <= table_d;
      end
   end

   for (genvar gi = 0; gi < NUM_AREGS; gi++) begin : g_out
      if (SHOW_NEXT) begin : g_next
         assign table_o[gi] = table_d[gi];
      end else begin : g_cur
         assign table_o[gi] = table_q[gi];
      end
   end

endmodule

// File: rtl/rename_unit.sv
// W-wide rename core: speculative MT, architectural AMT, intra-group RAW/WAW
// bypass, CDB ready wake-up, and the branch-recovery FSM that rebuilds MT
// from AMT once a mispredicted branch retires.
module rename_unit
   import rename_pkg::*;
#(
   parameter int DISPATCH_WIDTH = 2,
   parameter int RETIRE_WIDTH   = 2,
   parameter int CDB_WIDTH      = 2,
   parameter int NUM_AREGS      = DEF_NUM_AREGS,
   parameter int NUM_PREGS      = DEF_NUM_PREGS,
   parameter int AREG_W         = $clog2(NUM_AREGS),
   parameter int PREG_W         = $clog2(NUM_PREGS)
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]  num_dispatch,
   input  logic [DISPATCH_WIDTH*AREG_W-1:0]     rd,
   input  logic [DISPATCH_WIDTH*AREG_W-1:0]     rs1,
   input  logic [DISPATCH_WIDTH*AREG_W-1:0]     rs2,
   input  logic [DISPATCH_WIDTH-1:0]            has_dst,
   input  logic [DISPATCH_WIDTH-1:0]            rs1_used,
   input  logic [DISPATCH_WIDTH-1:0]            rs2_used,
   input  logic [DISPATCH_WIDTH*PREG_W-1:0]     new_preg,
   output logic [DISPATCH_WIDTH*(PREG_W+1)-1:0] p_rs1,
   output logic [DISPATCH_WIDTH*(PREG_W+1)-1:0] p_rs2,
   output logic [DISPATCH_WIDTH*PREG_W-1:0]     t_old,
   input  logic [RETIRE_WIDTH-1:0]              retire_en,
   input  logic [RETIRE_WIDTH*AREG_W-1:0]       retire_areg,
   input  logic [RETIRE_WIDTH*PREG_W-1:0]       retire_preg,
   input  logic [RETIRE_WIDTH-1:0]              retire_mispredict,
   input  logic [CDB_WIDTH-1:0]                 cdb_valid,
   input  logic [CDB_WIDTH*PREG_W-1:0]          cdb_tag,
   input  logic [CDB_WIDTH-1:0]                 cdb_mispredict,
   output logic                                 rename_stall,
   output logic [1:0]                           state_out
);

   localparam int W    = DISPATCH_WIDTH;
   localparam int R    = RETIRE_WIDTH;
   localparam int C    = CDB_WIDTH;
   localparam int ND_W = $clog2(W+1);
   localparam int E_W  = PREG_W + 1;
   localparam logic [E_W-1:0] ZERO_READY = {PREG_W'(ZERO_PREG), 1'b1};

   execution_state_e state_q;

   logic [AREG_W-1:0] rd_a       [W];
   logic [AREG_W-1:0] rs1_a      [W];
   logic [AREG_W-1:0] rs2_a      [W];
   logic [PREG_W-1:0] np_a       [W];
   logic [PREG_W-1:0] cdb_tag_a  [C];
   logic [E_W-1:0]    mt_table   [NUM_AREGS];
   logic [E_W-1:0]    amt_next   [NUM_AREGS];
   logic [E_W-1:0]    no_copy    [NUM_AREGS];
   logic [W-1:0]      mt_wr_en;
   logic [AREG_W-1:0] mt_wr_addr [W];
   logic [E_W-1:0]    mt_wr_data [W];
   logic [R-1:0]      amt_wr_en;
   logic [AREG_W-1:0] amt_wr_addr[R];
   logic [E_W-1:0]    amt_wr_data[R];
   logic [0:0]        amt_cdb_valid;
   logic [PREG_W-1:0] amt_cdb_tag[1];
   logic              retire_flush;
   logic              cdb_flush;
   logic              dispatch_ok;

   assign retire_flush  = |(retire_en & retire_mispredict);
   assign cdb_flush     = |(cdb_valid & cdb_mispredict);
   // A retiring mispredict squashes this cycle's dispatch writes.
   assign dispatch_ok   = (state_q == NORMAL) && !retire_flush;
   assign rename_stall  = (state_q != NORMAL);
   assign state_out     = state_q;
   assign amt_cdb_valid = 1'b0;
   assign amt_cdb_tag[0] = '0;

   for (genvar gi = 0; gi < C; gi++) begin : g_cdb
      assign cdb_tag_a[gi] = cdb_tag[gi*PREG_W +: PREG_W];
   end

   for (genvar gi = 0; gi < R; gi++) begin : g_retire
      assign amt_wr_addr[gi] = retire_areg[gi*AREG_W +: AREG_W];
      assign amt_wr_en[gi]   = retire_en[gi] && (amt_wr_addr[gi] != '0);
      assign amt_wr_data[gi] = {retire_preg[gi*PREG_W +: PREG_W], 1'b1};
   end

   for (genvar gi = 0; gi < NUM_AREGS; gi++) begin : g_nocopy
      assign no_copy[gi] = '0;
   end

   for (genvar gi = 0; gi < W; gi++) begin : g_slot
      logic [AREG_W-1:0] src_areg  [2];
      logic [E_W-1:0]    src_found [2];
      logic [PREG_W-1:0] old_tag;

      assign rd_a[gi]     = rd[gi*AREG_W +: AREG_W];
      assign rs1_a[gi]    = rs1[gi*AREG_W +: AREG_W];
      assign rs2_a[gi]    = rs2[gi*AREG_W +: AREG_W];
      assign np_a[gi]     = new_preg[gi*PREG_W +: PREG_W];
      assign src_areg[0]  = rs1_a[gi];
      assign src_areg[1]  = rs2_a[gi];

      // Source lookup: MT with CDB wake-up, overridden by the youngest older slot writing it.
      always_comb begin
         for (int k = 0; k < 2; k++) begin
            src_found[k] = mt_table[src_areg[k]];
            for (int c = 0; c < C; c++) begin
               if (cdb_valid[c] && (cdb_tag_a[c] == mt_table[src_areg[k]][E_W-1:1])) begin
                  src_found[k][0] = 1'b1;
               end
            end
            for (int j = 0; j < gi; j++) begin
               if (has_dst[j] && (rd_a[j] == src_areg[k]) && (rd_a[j] != '0)) begin
                  src_found[k] = {np_a[j], 1'b0};
               end
            end
         end
      end

      // Previous mapping of this slot's destination, with the same intra-group override.
      always_comb begin
         old_tag = mt_table[rd_a[gi]][E_W-1:1];
         for (int j = 0; j < gi; j++) begin
            if (has_dst[j] && (rd_a[j] == rd_a[gi]) && (rd_a[j] != '0)) begin
               old_tag = np_a[j];
            end
         end
      end

      assign p_rs1[gi*E_W +: E_W] = (rs1_used[gi] && (rs1_a[gi] != '0)) ? src_found[0] : ZERO_READY;
      assign p_rs2[gi*E_W +: E_W] = (rs2_used[gi] && (rs2_a[gi] != '0)) ? src_found[1] : ZERO_READY;
      // Instructions without a destination free their own freshly allocated tag.
      assign t_old[gi*PREG_W +: PREG_W] = (has_dst[gi] && (rd_a[gi] != '0)) ? old_tag : np_a[gi];

      assign mt_wr_en[gi]   = dispatch_ok && (ND_W'(gi) < num_dispatch)
                              && has_dst[gi] && (rd_a[gi] != '0);
      assign mt_wr_addr[gi] = rd_a[gi];
      assign mt_wr_data[gi] = {np_a[gi], 1'b0};
   end

   // Recovery FSM: a retiring mispredict jumps straight to RESTORE; a CDB
   // mispredict parks in WAIT_RETIRE until that branch retires.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= NORMAL;
      end else begin
         case (state_q)
            NORMAL: begin
               if (retire_flush) begin
                  state_q <= RESTORE;
               end else if (cdb_flush) begin
                  state_q <= WAIT_RETIRE;
               end
            end
            WAIT_RETIRE: begin
               if (retire_flush) begin
                  state_q <= RESTORE;
               end
            end
            default: state_q <= NORMAL;
         endcase
      end
   end

   // Speculative map; in RESTORE it reloads the AMT including this cycle's retires.
   // AMT entries are always ready, so the copied ready bits are already 1.
   map_table_bank #(
      .NUM_AREGS(NUM_AREGS), .AREG_W(AREG_W), .PREG_W(PREG_W),
      .NUM_WR(W), .NUM_CDB(C), .SHOW_NEXT(1'b0)
   ) u_mt (
      .clock(clock), .reset(reset),
      .wr_en(mt_wr_en), .wr_addr(mt_wr_addr), .wr_data(mt_wr_data),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag_a),
      .copy_en(state_q == RESTORE), .copy_data(amt_next),
      .table_o(mt_table)
   );

   // Architectural map; exposes its next value so RESTORE sees same-cycle retires.
   map_table_bank #(
      .NUM_AREGS(NUM_AREGS), .AREG_W(AREG_W), .PREG_W(PREG_W),
      .NUM_WR(R), .NUM_CDB(1), .SHOW_NEXT(1'b1)
   ) u_amt (
      .clock(clock), .reset(reset),
      .wr_en(amt_wr_en), .wr_addr(amt_wr_addr), .wr_data(amt_wr_data),
      .cdb_valid(amt_cdb_valid), .cdb_tag(amt_cdb_tag),
      .copy_en(1'b0), .copy_data(no_copy),
      .table_o(amt_next)
   );

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit (W=R=C=2, 32 aregs, 64 pregs).
module tb_rename_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  num_dispatch;
   logic [9:0]  rd, rs1, rs2;
   logic [1:0]  has_dst, rs1_used, rs2_used;
   logic [11:0] new_preg;
   logic [13:0] p_rs1, p_rs2;
   logic [11:0] t_old;
   logic [1:0]  retire_en, retire_mispredict;
   logic [9:0]  retire_areg;
   logic [11:0] retire_preg;
   logic [1:0]  cdb_valid, cdb_mispredict;
   logic [11:0] cdb_tag;
   logic        rename_stall;
   logic [1:0]  state_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   rename_unit dut (
      .clock(clock), .reset(reset), .num_dispatch(num_dispatch),
      .rd(rd), .rs1(rs1), .rs2(rs2),
      .has_dst(has_dst), .rs1_used(rs1_used), .rs2_used(rs2_used),
      .new_preg(new_preg), .p_rs1(p_rs1), .p_rs2(p_rs2), .t_old(t_old),
      .retire_en(retire_en), .retire_areg(retire_areg), .retire_preg(retire_preg),
      .retire_mispredict(retire_mispredict),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_mispredict(cdb_mispredict),
      .rename_stall(rename_stall), .state_out(state_out)
   );

   // Slot/port 1 fields sit in the upper half of every pair.
   typedef struct {
      string       name;
      logic [1:0]  nd;
      logic [9:0]  rd, rs1, rs2;
      logic [1:0]  hd, u1, u2;
      logic [11:0] np;
      logic [1:0]  ren, rmis;
      logic [9:0]  rareg;
      logic [11:0] rpreg;
      logic [1:0]  cv, cmis;
      logic [11:0] ct;
      logic [13:0] e_p1, e_p2;
      logic [11:0] e_told;
      logic        e_stall;
      logic [1:0]  e_state;
   } vec_t;

   vec_t tab[$];
   vec_t v;

   function automatic logic [6:0] tr(input int t, input int r);
      logic [6:0] x;
      x = {t[5:0], r[0]};
      return x;
   endfunction

   function automatic vec_t idle(input string nm);
      vec_t x;
      x.name = nm; x.nd = 0; x.rd = 0; x.rs1 = 0; x.rs2 = 0;
      x.hd = 0; x.u1 = 0; x.u2 = 0; x.np = 0;
      x.ren = 0; x.rmis = 0; x.rareg = 0; x.rpreg = 0;
      x.cv = 0; x.cmis = 0; x.ct = 0;
      x.e_p1 = {tr(0, 1), tr(0, 1)}; x.e_p2 = {tr(0, 1), tr(0, 1)};
      x.e_told = 0; x.e_stall = 0; x.e_state = 0;
      return x;
   endfunction

   task automatic drive(input vec_t x);
      num_dispatch = x.nd; rd = x.rd; rs1 = x.rs1; rs2 = x.rs2;
      has_dst = x.hd; rs1_used = x.u1; rs2_used = x.u2; new_preg = x.np;
      retire_en = x.ren; retire_mispredict = x.rmis;
      retire_areg = x.rareg; retire_preg = x.rpreg;
      cdb_valid = x.cv; cdb_mispredict = x.cmis; cdb_tag = x.ct;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Drive one cycle's inputs after the falling edge, check combinational
   // outputs and state before the next rising edge, which commits the cycle.
   task automatic run_vec(input vec_t x);
      @(negedge clock);
      drive(x);
      #2;
      check({x.name, ".p_rs1"}, 32'(p_rs1), 32'(x.e_p1));
      check({x.name, ".p_rs2"}, 32'(p_rs2), 32'(x.e_p2));
      check({x.name, ".t_old"}, 32'(t_old), 32'(x.e_told));
      check({x.name, ".stall"}, 32'(rename_stall), 32'(x.e_stall));
      check({x.name, ".state"}, 32'(state_out), 32'(x.e_state));
      $display("vec %-12s p_rs1=%h p_rs2=%h t_old=%h stall=%0d state=%0d",
               x.name, p_rs1, p_rs2, t_old, rename_stall, state_out);
   endtask

   initial begin
      // ---------------- table of single-cycle vectors ----------------
      v = idle("reset_read"); v.rd = {5'd0, 5'd7}; v.hd = 2'b01;
      v.rs1 = {5'd0, 5'd5}; v.u1 = 2'b01; v.np = {6'd21, 6'd20};
      v.e_p1 = {tr(0, 1), tr(5, 1)}; v.e_told = {6'd21, 6'd7}; tab.push_back(v);

      v = idle("raw_waw"); v.nd = 2; v.rd = {5'd3, 5'd3}; v.hd = 2'b11;
      v.rs1 = {5'd3, 5'd1}; v.u1 = 2'b11; v.rs2 = {5'd0, 5'd2}; v.u2 = 2'b11;
      v.np = {6'd41, 6'd40};
      v.e_p1 = {tr(40, 0), tr(1, 1)}; v.e_p2 = {tr(0, 1), tr(2, 1)};
      v.e_told = {6'd40, 6'd3}; tab.push_back(v);

      v = idle("cdb_fwd"); v.rs1 = {5'd3, 5'd3}; v.u1 = 2'b11;
      v.rs2 = {5'd4, 5'd0}; v.u2 = 2'b10; v.np = {6'd11, 6'd10};
      v.cv = 2'b10; v.ct = {6'd41, 6'd3};
      v.e_p1 = {tr(41, 1), tr(41, 1)}; v.e_p2 = {tr(4, 1), tr(0, 1)};
      v.e_told = {6'd11, 6'd10}; tab.push_back(v);

      v = idle("cdb_commit"); v.rs1 = {5'd0, 5'd3}; v.u1 = 2'b01;
      v.rs2 = {5'd3, 5'd0}; v.u2 = 2'b10;
      v.e_p1 = {tr(0, 1), tr(41, 1)}; v.e_p2 = {tr(41, 1), tr(0, 1)}; tab.push_back(v);

      v = idle("x0_dst_src"); v.nd = 2; v.rd = {5'd5, 5'd0}; v.hd = 2'b11;
      v.u1 = 2'b11; v.rs2 = {5'd3, 5'd0}; v.u2 = 2'b10; v.np = {6'd43, 6'd42};
      v.e_p2 = {tr(41, 1), tr(0, 1)}; v.e_told = {6'd5, 6'd42}; tab.push_back(v);

      v = idle("x5_written"); v.rs1 = {5'd0, 5'd5}; v.u1 = 2'b01;
      v.rd = {5'd5, 5'd0}; v.hd = 2'b10; v.np = {6'd44, 6'd0};
      v.e_p1 = {tr(0, 1), tr(43, 0)}; v.e_told = {6'd43, 6'd0}; tab.push_back(v);

      v = idle("waw_same_rd"); v.nd = 2; v.rd = {5'd6, 5'd6}; v.hd = 2'b11;
      v.rs1 = {5'd6, 5'd0}; v.u1 = 2'b10; v.np = {6'd46, 6'd45};
      v.e_p1 = {tr(45, 0), tr(0, 1)}; v.e_told = {6'd45, 6'd6}; tab.push_back(v);

      v = idle("waw_winner"); v.rs1 = {5'd5, 5'd6}; v.u1 = 2'b11;
      v.e_p1 = {tr(43, 0), tr(46, 0)}; tab.push_back(v);

      v = idle("disp_vs_cdb"); v.nd = 1; v.rd = {5'd8, 5'd5}; v.hd = 2'b11;
      v.np = {6'd48, 6'd47}; v.rs1 = {5'd5, 5'd5}; v.u1 = 2'b11;
      v.rs2 = {5'd8, 5'd0}; v.u2 = 2'b10; v.cv = 2'b01; v.ct = {6'd0, 6'd43};
      v.e_p1 = {tr(47, 0), tr(43, 1)}; v.e_p2 = {tr(8, 1), tr(0, 1)};
      v.e_told = {6'd8, 6'd43}; tab.push_back(v);

      v = idle("nd_gating"); v.rs1 = {5'd8, 5'd5}; v.u1 = 2'b11;
      v.e_p1 = {tr(8, 1), tr(47, 0)}; tab.push_back(v);

      // ---------------- reset ----------------
      drive(idle("rst"));
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      for (int i = 0; i < tab.size(); i++) run_vec(tab[i]);

      // ---------------- CDB mispredict, wait, retire, restore ----------------
      v = idle("a1_cdb_misp"); v.cv = 2'b01; v.cmis = 2'b01; v.ct = {6'd0, 6'd60};
      run_vec(v);
      v = idle("a2_stalled"); v.nd = 2; v.rd = {5'd11, 5'd10}; v.hd = 2'b11;
      v.np = {6'd56, 6'd55}; v.cv = 2'b01; v.cmis = 2'b01; v.ct = {6'd0, 6'd60};
      v.ren = 2'b01; v.rareg = {5'd0, 5'd12}; v.rpreg = {6'd0, 6'd57};
      v.e_told = {6'd11, 6'd10}; v.e_stall = 1; v.e_state = 1; run_vec(v);
      v = idle("a3_wait"); v.e_stall = 1; v.e_state = 1; run_vec(v);
      v = idle("a4_ret_misp"); v.ren = 2'b11; v.rareg = {5'd4, 5'd4};
      v.rpreg = {6'd50, 6'd49}; v.rmis = 2'b10;
      v.e_stall = 1; v.e_state = 1; run_vec(v);
      v = idle("a5_restore"); v.e_stall = 1; v.e_state = 2; run_vec(v);
      v = idle("a6_restored"); v.rs1 = {5'd10, 5'd4}; v.u1 = 2'b11;
      v.rs2 = {5'd12, 5'd5}; v.u2 = 2'b11;
      v.e_p1 = {tr(10, 1), tr(50, 1)}; v.e_p2 = {tr(57, 1), tr(5, 1)}; run_vec(v);

      // ---------------- retire mispredict in NORMAL with dispatch ----------------
      v = idle("b1_flush_disp"); v.nd = 2; v.rd = {5'd9, 5'd9}; v.hd = 2'b11;
      v.np = {6'd59, 6'd58}; v.ren = 2'b01; v.rareg = {5'd0, 5'd9};
      v.rpreg = {6'd0, 6'd61}; v.rmis = 2'b01;
      v.e_told = {6'd58, 6'd9}; run_vec(v);
      v = idle("b2_restore"); v.ren = 2'b01; v.rareg = {5'd0, 5'd13};
      v.rpreg = {6'd0, 6'd62}; v.e_stall = 1; v.e_state = 2; run_vec(v);
      v = idle("b3_after"); v.rs1 = {5'd13, 5'd9}; v.u1 = 2'b11;
      v.rs2 = {5'd3, 5'd0}; v.u2 = 2'b10;
      v.e_p1 = {tr(62, 1), tr(61, 1)}; v.e_p2 = {tr(3, 1), tr(0, 1)}; run_vec(v);

      // ---------------- reset during WAIT_RETIRE ----------------
      v = idle("c1_write14"); v.nd = 1; v.rd = {5'd0, 5'd14}; v.hd = 2'b01;
      v.np = {6'd0, 6'd63}; v.e_told = {6'd0, 6'd14}; run_vec(v);
      v = idle("c2_cdb_misp"); v.cv = 2'b01; v.cmis = 2'b01; v.ct = {6'd0, 6'd1};
      run_vec(v);
      v = idle("c3_waiting"); v.rs1 = {5'd0, 5'd14}; v.u1 = 2'b01;
      v.e_p1 = {tr(0, 1), tr(63, 0)}; v.e_stall = 1; v.e_state = 1; run_vec(v);
      @(negedge clock);
      reset = 1'b1;
      drive(idle("rst2"));
      @(posedge clock);
      #1 reset = 1'b0;
      v = idle("c4_post_rst"); v.rs1 = {5'd4, 5'd14}; v.u1 = 2'b11;
      v.e_p1 = {tr(4, 1), tr(14, 1)}; run_vec(v);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
W-wide register-rename core for the out-of-order pipeline. It holds the speculative map table (MT) and the architectural map table (AMT). It resolves intra-group RAW/WAW dependencies across W dispatch slots and applies CDB ready updates. It runs a branch-recovery FSM that stalls rename and restores MT from AMT when a mispredicted branch retires. It is a parametrised successor to the fixed 2-wide rename logic; ROB, free list and RS stay external.

Parameters:
DISPATCH_WIDTH, 2, rename slots per cycle (W, 1..4)
RETIRE_WIDTH, 2, retire ports into AMT (R)
CDB_WIDTH, 2, CDB broadcast ports (C)
NUM_AREGS, 32, architectural registers; areg 0 is hardwired zero
NUM_PREGS, 64, physical registers
AREG_W, $clog2(NUM_AREGS), areg index width
PREG_W, $clog2(NUM_PREGS), preg index width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
num_dispatch  in  $clog2(W+1)  slots renamed this cycle; slots 0..n-1 valid, slot 0 oldest
rd, rs1, rs2  in  W*AREG_W each  arch regs per slot
has_dst, rs1_used, rs2_used  in  W each  decode flags per slot
new_preg  in  W*PREG_W  free-list preg per slot
p_rs1, p_rs2  out  W*(PREG_W+1)  {tag,ready} per slot source
t_old  out  W*PREG_W  preg freed when the slot retires
retire_en  in  R  retire valid per port, port 0 oldest
retire_areg  in  R*AREG_W  retiring arch dst
retire_preg  in  R*PREG_W  retiring tag
retire_mispredict  in  R  retiring branch mispredicted
cdb_valid  in  C  CDB valid
cdb_tag  in  C*PREG_W  CDB completing preg
cdb_mispredict  in  C  branch resolved mispredicted
rename_stall  out  1  dispatch must present num_dispatch=0
state_out  out  2  FSM state, for ROB rewind control

Behaviour:
- Reset: MT[a] = AMT[a] = {a, ready=1} for every a. State NORMAL. rename_stall=0. Reset mid-recovery aborts recovery the same way.
- Read path (combinational, current MT) for slot i, source s:
  - If s unused or s==0: {0, 1}.
  - Else if some j<i has has_dst, rd_j==s and rd_j!=0: {new_preg_j, 0}, using the largest such j.
  - Else MT[s], with ready forced to 1 if any cdb_valid port carries the same tag this cycle.
- t_old[i]:
  - If has_dst and rd!=0: the mapping of rd_i, with the same intra-group override.
  - Else new_preg[i] (no-dst instructions free their own tag).
  - Outputs are valid for all W slots regardless of num_dispatch.
- MT write at posedge, NORMAL state only:
  - Each valid slot with has_dst & rd!=0 writes MT[rd] <= {new_preg, 0}.
  - When several slots share an rd, the highest slot wins.
  - Dispatch writes override same-cycle CDB ready updates.
  - CDB: every MT entry whose tag matches a valid cdb_tag has ready set to 1.
- AMT write at posedge:
  - Each retire_en port with areg!=0 writes AMT[areg] <= {preg, 1}; the highest port wins.
  - AMT writes happen in every state.
  - The ROB guarantees no port younger than a mispredicting port is enabled.
- FSM (2-bit: NORMAL=0, WAIT_RETIRE=1, RESTORE=2):
  - NORMAL -> RESTORE if any retire_en&retire_mispredict this cycle (takes priority).
  - NORMAL -> WAIT_RETIRE if any cdb_valid&cdb_mispredict.
  - WAIT_RETIRE: stays until a retiring misprediction, then -> RESTORE. Further CDB mispredicts are ignored.
  - RESTORE: MT[a] <= AMT-next[a] (this cycle's retire writes included) with ready=1, for all a. Then -> NORMAL.
- rename_stall = (state != NORMAL). When stalled, num_dispatch is ignored and no MT dispatch writes occur.
- Latency:
  - Rename is 0-cycle combinational; MT updates are visible the next cycle.
  - Recovery costs exactly one RESTORE cycle after the retire of the mispredicted branch.
  - In NORMAL with a same-cycle retiring mispredict, the MT dispatch writes of that cycle are discarded.

Decomposition:
- rename_pkg holds AREG, PREG and TAG_AND_READY typedefs, the EXECUTION_STATE enum (NORMAL/WAIT_RETIRE/RESTORE), and the ZERO_PREG constant.
- Sub-module map_table_bank (params NUM_WR, NUM_CDB; priority write ports, CDB ready update, full-table copy-in, full-table out) is instantiated once for MT and once for AMT.
- Intra-group dependency logic stays in rename_unit as a generate loop.

Test Plan:
- Reset, then slot0 reads rs1=5 -> p_rs1={5,1}; t_old for rd=7 -> 7.
- W=2: slot0 "add x3" new_preg=40, slot1 reads rs1=x3 with rd=x3, new_preg=41 -> slot1 p_rs1={40,0}, t_old=40. Next cycle MT[3]={41,0}.
- MT[3]={41,0}, cdb_tag=41 valid same cycle as a read of x3 -> ready=1. Next cycle MT[3]={41,1}.
- Dispatch rd=x0 or rs1=x0 -> MT[0] unchanged, p_rs1={0,1}, t_old=new_preg.
- cdb_mispredict -> WAIT_RETIRE; rename_stall=1 and num_dispatch=2 writes nothing. Two cycles later retire areg 4 tag 50 with mispredict -> RESTORE. Next cycle MT equals AMT (MT[4]={50,1}); then NORMAL and stall=0.
- Retire-misprediction in NORMAL in the same cycle as num_dispatch=2 with rd=9 -> MT[9] comes from AMT and no dispatch write survives; reset asserted during WAIT_RETIRE -> identity maps and NORMAL.
